out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Per-output-port round-robin arbiter for the 5-port mesh router. One instance sits in front of each switch output (L, N, E, S, W). It watches the five input blocks' request codes, picks one owner in round-robin order, and locks the output to that owner until its request drops. It drives the per-input grants, the crossbar select and the output valid, and is throttled by the downstream buffer's full flag.

## Interface
- DATA_WIDTH, 8, flit width (pass-through only, sizes nothing internally)
- N_REGISTER, 3, width of request codes
- PORT_CODE, 3'd1, request code that addresses this output (1=L, 2=N, 3=E, 4=S, 5=W)
- MAX_HOLD, 16, maximum owner hold in cycles (used only with ARB_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- request_L, request_N, request_E, request_S, request_W  in  N_REGISTER  destination code from each input block; 0 means no request; 6 and 7 are ignored
- full  in  1  downstream buffer/OCM full; 1 blocks transfer
- grant_L, grant_N, grant_E, grant_S, grant_W  out  1  pop/forward permission to that input block
- sel  out  3  crossbar select, input index of owner (L=0, N=1, E=2, S=3, W=4)
- val_out  out  1  flit valid toward the neighbour
- busy  out  1  output is locked to an owner

## Operation
- req[i] = (request_i == PORT_CODE), index order L,N,E,S,W = 0..4.
- Registers: state {IDLE, BUSY}, owner[2:0], ptr[2:0] (next highest priority index, 0..4).
- IDLE: if any req and !full, the winner is the first set req[i] scanning ptr, ptr+1, ... mod 5. On the next edge: state=BUSY, owner=winner, ptr=(winner+1) mod 5. If full=1 or no req, remain IDLE and leave ptr unchanged.
- BUSY: grant[owner] = ~full; all other grants are 0. val_out = grant[owner]; sel = owner; busy = 1.
- BUSY -> IDLE on the edge where req[owner]=0. Requests from non-owners are ignored while BUSY.
- The outputs depend only on the registers and full (Moore plus the full gate). There is no combinational path from request_* to grant_*.
- Modulo-5 wrap: ptr=4 with a winner of 4 gives ptr=0. ptr and owner never take values 5..7.

## Timing
- Reset values: state=IDLE, owner=0, ptr=0. All grants 0, sel=0, val_out=0, busy=0.
- Arbitration latency: a request first seen at edge t gives grant high during cycle t+1, provided full=0.
- full rising mid-packet: the grant drops in the same cycle (combinational gate). Ownership is kept and the grant resumes when full falls.
- Release: the owner's request drops at edge t, the state becomes IDLE at t, and the earliest new grant is at t+1. This is always one idle cycle between packets.
- Owner drop and new request in the same cycle: go IDLE first, then arbitrate next cycle with the updated ptr.
- rst asserted mid-packet: return to reset values on that edge. The current owner loses its lock and ptr restarts at 0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Adds hold counter hcnt, width $clog2(MAX_HOLD+1). It clears on entering BUSY and increments each BUSY cycle.
  - When hcnt == MAX_HOLD-1 and req[owner] is still 1, the block forces BUSY -> IDLE.
  - ptr has already moved past the owner, so the other requesters win first. The stalled owner re-competes normally.
- ARB_TIMEOUT_EN undefined: there is no counter and no forced release, so an owner can hold the output indefinitely. MAX_HOLD is unused.

## Structure
- Shared router package:
  - port index constants (IDX_L..IDX_W)
  - request code constants (REQ_NONE=0, REQ_L..REQ_W=1..5)
  - arbiter state encoding
  - N_PORTS=5
- One sub-module, rr_pick5: purely combinational. It takes a 5-bit req and ptr and returns a winner index and a valid flag. This lets the arbiter and future VC allocators share it.
- The switch instantiates five out_port_arbiter instances, one per PORT_CODE, and ORs the five per-input grant vectors.

## Test plan
- Reset: hold rst 2 cycles with all requests = PORT_CODE -> all grants 0, sel=0, val_out=0, busy=0. First grant is grant_L in the cycle after rst falls.
- Round-robin: L, N and W request continuously and each drops its request for 1 cycle after 3 grant cycles -> owners in order L, N, W, L. There is exactly one idle cycle between owners and ptr wraps 4 -> 0.
- Backpressure: owner E granted, then full=1 for 4 cycles -> grant_E=0 and val_out=0 during those cycles, busy stays 1. The grant resumes the same cycle full=0.
- Code filtering: request_S=3'd6, request_N=other port's code -> no grant and busy stays 0. Then request_N=PORT_CODE -> grant_N one cycle later.
- Mid-packet reset: owner S active, rst pulsed for 1 cycle -> next cycle all outputs 0. With L and S both requesting afterwards, L wins (ptr=0).
- ARB_TIMEOUT_EN, MAX_HOLD=4: W holds its request and N also requests -> after 4 BUSY cycles W is released, one idle cycle follows, then N is granted.

Source files
------------

// File: rtl/out_port_arbiter_pkg.sv
// Shared router definitions: port indices, request codes, arbiter states.
package out_port_arbiter_pkg;

    localparam int unsigned N_PORTS = 5;

    localparam logic [2:0] IDX_L = 3'd0;
    localparam logic [2:0] IDX_N = 3'd1;
    localparam logic [2:0] IDX_E = 3'd2;
    localparam logic [2:0] IDX_S = 3'd3;
    localparam logic [2:0] IDX_W = 3'd4;

    localparam logic [2:0] REQ_NONE = 3'd0;
    localparam logic [2:0] REQ_L    = 3'd1;
    localparam logic [2:0] REQ_N    = 3'd2;
    localparam logic [2:0] REQ_E    = 3'd3;
    localparam logic [2:0] REQ_S    = 3'd4;
    localparam logic [2:0] REQ_W    = 3'd5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Next port index with modulo-5 wrap (W -> L).
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= IDX_W) ? IDX_L : idx + 3'd1;
    endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick5.sv
// Combinational 5-way round-robin pick: first set req starting at ptr.
module rr_pick5
    import out_port_arbiter_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] winner,
    output logic       valid
);

    logic [2:0] idx;

    // Scan ptr, ptr+1, ... mod 5 and keep the first requester found.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = ptr;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output round-robin arbiter with owner lock and full gating.
// Optional owner hold limit: define ARB_TIMEOUT_EN.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    N_REGISTER = 3,
    parameter logic [N_REGISTER-1:0] PORT_CODE  = 3'd1,
    parameter int                    MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REGISTER-1:0] request_L,
    input  logic [N_REGISTER-1:0] request_N,
    input  logic [N_REGISTER-1:0] request_E,
    input  logic [N_REGISTER-1:0] request_S,
    input  logic [N_REGISTER-1:0] request_W,
    input  logic                  full,
    output logic                  grant_L,
    output logic                  grant_N,
    output logic                  grant_E,
    output logic                  grant_S,
    output logic                  grant_W,
    output logic [2:0]            sel,
    output logic                  val_out,
    output logic                  busy
);

    if (DATA_WIDTH < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("out_port_arbiter: DATA_WIDTH and MAX_HOLD must be >= 1");
    end

    arb_state_t state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic [4:0] req;
    logic [4:0] grant_vec;
    logic [2:0] pick_winner;
    logic       pick_valid;
    logic       owner_req;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned          HCNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HCNT_W-1:0]    HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
`endif

    assign req[IDX_L] = (request_L == PORT_CODE);
    assign req[IDX_N] = (request_N == PORT_CODE);
    assign req[IDX_E] = (request_E == PORT_CODE);
    assign req[IDX_S] = (request_S == PORT_CODE);
    assign req[IDX_W] = (request_W == PORT_CODE);

    assign owner_req = req[owner_q];

    rr_pick5 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // State, owner, pointer (and hold counter) registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    // Next-state: arbitrate in IDLE, hold the lock in BUSY until release.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hcnt_d  = hcnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid && !full) begin
                    state_d = ARB_BUSY;
                    owner_d = pick_winner;
                    ptr_d   = next_idx(pick_winner);
`ifdef ARB_TIMEOUT_EN
                    hcnt_d  = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (!owner_req) begin
                    state_d = ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d = ARB_IDLE;
                end else begin
                    hcnt_d  = hcnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Moore outputs gated only by full; sel parks at 0 while idle.
    always_comb begin
        grant_vec = '0;
        busy      = (state_q == ARB_BUSY);
        sel       = busy ? owner_q : '0;
        if (busy) begin
            grant_vec[owner_q] = ~full;
        end
        val_out   = busy & ~full;
    end

    assign grant_L = grant_vec[IDX_L];
    assign grant_N = grant_vec[IDX_N];
    assign grant_E = grant_vec[IDX_E];
    assign grant_S = grant_vec[IDX_S];
    assign grant_W = grant_vec[IDX_W];

endmodule

// File: tb/tb_out_port_arbiter.sv
// Scoreboard bench for out_port_arbiter (PORT_CODE = L, MAX_HOLD = 4).
module tb_out_port_arbiter;

    typedef struct packed {
        logic [4:0] grant;  // {W,S,E,N,L}
        logic [2:0] sel;
        logic       val;
        logic       busy;
    } exp_t;

    localparam logic [2:0] P = 3'd1;  // this port's code
    localparam logic [2:0] O = 3'd2;  // another port's code
    localparam logic [2:0] Z = 3'd0;

    localparam logic [4:0] G0 = 5'b00000;
    localparam logic [4:0] GL = 5'b00001;
    localparam logic [4:0] GN = 5'b00010;
    localparam logic [4:0] GE = 5'b00100;
    localparam logic [4:0] GS = 5'b01000;
    localparam logic [4:0] GW = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] request_L = P, request_N = P, request_E = P, request_S = P, request_W = P;
    logic       full = 1'b0;
    logic       grant_L, grant_N, grant_E, grant_S, grant_W;
    logic [2:0] sel;
    logic       val_out, busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    out_port_arbiter #(
        .DATA_WIDTH (8),
        .N_REGISTER (3),
        .PORT_CODE  (3'd1),
        .MAX_HOLD   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request_L (request_L),
        .request_N (request_N),
        .request_E (request_E),
        .request_S (request_S),
        .request_W (request_W),
        .full      (full),
        .grant_L   (grant_L),
        .grant_N   (grant_N),
        .grant_E   (grant_E),
        .grant_S   (grant_S),
        .grant_W   (grant_W),
        .sel       (sel),
        .val_out   (val_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the edge and queue the outputs expected in this cycle.
    task automatic cyc(input logic r, input logic [2:0] l, n, e, s, w, input logic f,
                       input logic [4:0] eg, input logic [2:0] es, input logic ev, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; request_L = l; request_N = n; request_E = e; request_S = s; request_W = w; full = f;
        x.grant = eg; x.sel = es; x.val = ev; x.busy = eb;
        sb.push_back(x);
    endtask

    // Compare queued expectations mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("grant", {27'd0, grant_W, grant_S, grant_E, grant_N, grant_L}, {27'd0, x.grant});
            check("sel",   {29'd0, sel},  {29'd0, x.sel});
            check("val",   {31'd0, val_out}, {31'd0, x.val});
            check("busy",  {31'd0, busy}, {31'd0, x.busy});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two cycles with every input requesting this port
        cyc(1, P, P, P, P, P, 0, G0, 0, 0, 0);
        cyc(1, P, P, P, P, P, 0, G0, 0, 0, 0);
        cyc(0, P, P, P, P, P, 0, G0, 0, 0, 0);
        // round robin L -> N -> W -> L, one idle cycle between owners
        cyc(0, P, P, Z, Z, P, 0, GL, 0, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, GL, 0, 1, 1);
        cyc(0, Z, P, Z, Z, P, 0, GL, 0, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, G0, 0, 0, 0);
        cyc(0, P, P, Z, Z, P, 0, GN, 1, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, GN, 1, 1, 1);
        cyc(0, P, Z, Z, Z, P, 0, GN, 1, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, G0, 0, 0, 0);
        cyc(0, P, P, Z, Z, P, 0, GW, 4, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, GW, 4, 1, 1);
        cyc(0, P, P, Z, Z, Z, 0, GW, 4, 1, 1);
        cyc(0, P, P, Z, Z, P, 0, G0, 0, 0, 0);
        cyc(0, Z, Z, Z, Z, Z, 0, GL, 0, 1, 1);   // ptr wrapped 4 -> 0
        // backpressure on owner E
        cyc(0, Z, Z, P, Z, Z, 0, G0, 0, 0, 0);
        cyc(0, Z, Z, P, Z, Z, 0, GE, 2, 1, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, Z, Z, P, Z, Z, 1, G0, 2, 0, 1);
        cyc(0, Z, Z, Z, Z, Z, 0, GE, 2, 1, 1);
        // full blocks arbitration while idle
        cyc(0, Z, P, Z, Z, Z, 1, G0, 0, 0, 0);
        cyc(0, Z, P, Z, Z, Z, 1, G0, 0, 0, 0);
        cyc(0, Z, P, Z, Z, Z, 0, G0, 0, 0, 0);
        cyc(0, Z, Z, Z, Z, Z, 0, GN, 1, 1, 1);
        // code filtering: 6 and another port's code are ignored
        cyc(0, Z, O, Z, 3'd6, Z, 0, G0, 0, 0, 0);
        cyc(0, Z, O, Z, 3'd6, Z, 0, G0, 0, 0, 0);
        cyc(0, Z, P, Z, 3'd6, Z, 0, G0, 0, 0, 0);
        cyc(0, Z, Z, Z, Z, Z, 0, GN, 1, 1, 1);
        // mid-packet reset while S owns; ptr restarts at 0 so L beats W
        cyc(0, Z, Z, Z, P, Z, 0, G0, 0, 0, 0);
        cyc(1, Z, Z, Z, P, Z, 0, GS, 3, 1, 1);
        cyc(0, P, Z, Z, P, P, 0, G0, 0, 0, 0);
        cyc(0, Z, Z, Z, Z, Z, 0, GL, 0, 1, 1);
        // W holds while N waits
        cyc(0, Z, Z, Z, Z, P, 0, G0, 0, 0, 0);
        cyc(0, Z, P, Z, Z, P, 0, GW, 4, 1, 1);
        cyc(0, Z, P, Z, Z, P, 0, GW, 4, 1, 1);
        cyc(0, Z, P, Z, Z, P, 0, GW, 4, 1, 1);
        cyc(0, Z, P, Z, Z, P, 0, GW, 4, 1, 1);
`ifdef ARB_TIMEOUT_EN
        cyc(0, Z, P, Z, Z, P, 0, G0, 0, 0, 0);   // forced release after 4 cycles
        cyc(0, Z, Z, Z, Z, Z, 0, GN, 1, 1, 1);
`else
        cyc(0, Z, P, Z, Z, P, 0, GW, 4, 1, 1);   // no hold limit
        cyc(0, Z, Z, Z, Z, Z, 0, GW, 4, 1, 1);
`endif
        cyc(0, Z, Z, Z, Z, Z, 0, G0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
